// File: rtl/chord_pkg.sv
// Shared constants for the chord sequencer: note numbers, chord codes, the
// nibble layout of the decoded 4-note word and the sequencer state type.
package chord_pkg;

  localparam logic [3:0] NOTE_C  = 4'd0;
  localparam logic [3:0] NOTE_CS = 4'd1;
  localparam logic [3:0] NOTE_D  = 4'd2;
  localparam logic [3:0] NOTE_DS = 4'd3;
  localparam logic [3:0] NOTE_E  = 4'd4;
  localparam logic [3:0] NOTE_F  = 4'd5;
  localparam logic [3:0] NOTE_FS = 4'd6;
  localparam logic [3:0] NOTE_G  = 4'd7;
  localparam logic [3:0] NOTE_GS = 4'd8;
  localparam logic [3:0] NOTE_A  = 4'd9;
  localparam logic [3:0] NOTE_AS = 4'd10;
  localparam logic [3:0] NOTE_B  = 4'd11;

  typedef enum logic [3:0] {
    REST   = 4'd0,
    MAJ7   = 4'd1,
    MIN7   = 4'd2,
    DOM7   = 4'd3,
    MIN7B5 = 4'd4,
    AUG7   = 4'd5,
    SUS7   = 4'd6,
    DIM7   = 4'd7
  } chord_code_t;

  // note1 sits in the top nibble, note4 in the bottom one.
  localparam int NOTE1_LSB = 12;
  localparam int NOTE2_LSB = 8;
  localparam int NOTE3_LSB = 4;
  localparam int NOTE4_LSB = 0;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } seq_state_t;

  // Keys outside C..B have no meaning downstream, so they collapse to C.
  function automatic logic [3:0] clamp_key(input logic [3:0] k);
    return (k > NOTE_B) ? NOTE_C : k;
  endfunction

  function automatic logic [3:0] note_at(input logic [15:0] notes, input logic [1:0] slot);
    logic [3:0] n;
    case (slot)
      2'd0:    n = notes[NOTE1_LSB +: 4];
      2'd1:    n = notes[NOTE2_LSB +: 4];
      2'd2:    n = notes[NOTE3_LSB +: 4];
      default: n = notes[NOTE4_LSB +: 4];
    endcase
    return n;
  endfunction

endpackage

// File: rtl/seq_timebase.sv
// Tick / sub-beat / beat counters for the chord sequencer. Counters run only
// while 'run' is high and are parked at zero otherwise.
module seq_timebase
  import chord_pkg::*;
#(
  parameter int TICK_DIV        = 8,
  parameter int BEATS_PER_CHORD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  output logic       beat,
  output logic       step_end,
  output logic [1:0] sub_beat
);

  localparam int SUB_DIV = TICK_DIV / 4;
  localparam int TW      = $clog2(TICK_DIV);
  localparam int SW      = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam int BW      = (BEATS_PER_CHORD > 1) ? $clog2(BEATS_PER_CHORD) : 1;

  logic [TW-1:0] tick;
  logic [SW-1:0] sub_tick;
  logic [BW-1:0] beat_cnt;
  logic          tick_last;
  logic          sub_last;
  logic          beat_last;

  assign tick_last = (tick == TW'(TICK_DIV - 1));
  assign sub_last  = (sub_tick == SW'(SUB_DIV - 1));
  assign beat_last = (beat_cnt == BW'(BEATS_PER_CHORD - 1));

  assign beat     = run && tick_last;
  assign step_end = beat && beat_last;

  // Four sub-beats exactly fill one beat, so sub_beat wraps with tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick     <= '0;
      sub_tick <= '0;
      sub_beat <= 2'd0;
      beat_cnt <= '0;
    end else if (!run) begin
      tick     <= '0;
      sub_tick <= '0;
      sub_beat <= 2'd0;
      beat_cnt <= '0;
    end else begin
      tick <= tick_last ? '0 : tick + TW'(1);
      if (sub_last) begin
        sub_tick <= '0;
        sub_beat <= sub_beat + 2'd1;
      end else begin
        sub_tick <= sub_tick + SW'(1);
      end
      if (tick_last) begin
        beat_cnt <= beat_last ? '0 : beat_cnt + BW'(1);
      end
    end
  end

endmodule

// File: rtl/chord_sequencer.sv
// Chord progression sequencer: stores up to DEPTH chord codes and plays them
// at a fixed tempo. Arpeggiator enabled by defining CHORD_SEQ_ARPEGGIO_EN.
module chord_sequencer
  import chord_pkg::*;
#(
  parameter int  TICK_DIV        = 8,
  parameter int  BEATS_PER_CHORD = 4,
  parameter int  DEPTH           = 8,
  localparam int AW              = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [3:0]    wr_chord,
  input  logic [AW:0]   prog_len,
  input  logic [3:0]    key_in,
  input  logic          loop_en,
  input  logic          start,
  input  logic          stop,
  input  logic [15:0]   notes_for_chord,
  output logic [3:0]    chord_out,
  output logic [3:0]    key_out,
  output logic          playing,
  output logic [AW-1:0] step_idx,
  output logic          beat,
  output logic          chord_change,
  output logic          done,
  output logic [3:0]    arp_note,
  output logic          arp_valid
);

  // start/stop are single-cycle pulses; stop wins when both arrive together.
  seq_state_t    state;
  logic [3:0]    mem [DEPTH];
  logic [AW:0]   eff_len;
  logic          at_last;
  logic [AW-1:0] next_idx;
  logic          run;
  logic          step_end;
  logic [1:0]    sub_beat;

  assign run      = (state == PLAY);
  assign eff_len  = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
  assign at_last  = ({1'b0, step_idx} == (eff_len - (AW+1)'(1)));
  assign next_idx = at_last ? '0 : step_idx + AW'(1);

  seq_timebase #(
    .TICK_DIV        (TICK_DIV),
    .BEATS_PER_CHORD (BEATS_PER_CHORD)
  ) u_timebase (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .beat     (beat),
    .step_end (step_end),
    .sub_beat (sub_beat)
  );

  // Progression storage survives reset; it is only writable while idle.
  always_ff @(posedge clk) begin
    if (wr_en && state == IDLE) begin
      mem[wr_addr] <= wr_chord;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      playing      <= 1'b0;
      step_idx     <= '0;
      chord_out    <= 4'd0;
      key_out      <= 4'd0;
      chord_change <= 1'b0;
      done         <= 1'b0;
    end else begin
      chord_change <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop && eff_len != '0) begin
            state        <= PLAY;
            playing      <= 1'b1;
            step_idx     <= '0;
            chord_out    <= mem[0];
            key_out      <= clamp_key(key_in);
            chord_change <= 1'b1;
          end
        end
        PLAY: begin
          if (stop) begin
            state     <= IDLE;
            playing   <= 1'b0;
            step_idx  <= '0;
            chord_out <= 4'd0;
            key_out   <= 4'd0;
          end else if (step_end) begin
            if (at_last && !loop_en) begin
              state     <= IDLE;
              playing   <= 1'b0;
              step_idx  <= '0;
              chord_out <= 4'd0;
              key_out   <= 4'd0;
              done      <= 1'b1;
            end else begin
              // Key is re-sampled only here, so mid-step key changes wait.
              step_idx     <= next_idx;
              chord_out    <= mem[next_idx];
              key_out      <= clamp_key(key_in);
              chord_change <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CHORD_SEQ_ARPEGGIO_EN
  // One cycle behind the tick count; silent while idle or on a rest step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arp_note  <= 4'd0;
      arp_valid <= 1'b0;
    end else if (playing && chord_out != REST) begin
      arp_note  <= note_at(notes_for_chord, sub_beat);
      arp_valid <= 1'b1;
    end else begin
      arp_note  <= 4'd0;
      arp_valid <= 1'b0;
    end
  end
`else
  logic unused_arp;
  assign unused_arp = ^{notes_for_chord, sub_beat};
  assign arp_note   = 4'd0;
  assign arp_valid  = 1'b0;
`endif

endmodule

// File: doc/chord_sequencer.md
Name: chord_sequencer

Overview:
- Steps a programmed chord progression at a fixed tempo and drives the chord/key inputs of the chord-to-notes decoder.
- Holds up to DEPTH chord codes. Plays them in order, BEATS_PER_CHORD beats each, with optional looping.
- Sits between the user-control front end (progression entry, start/stop, key select) and the chord-to-notes datapath. Optionally arpeggiates the decoded 4-note chord.

Parameters:
- TICK_DIV, 8, clk cycles per beat; must be ≥4 and divisible by 4.
- BEATS_PER_CHORD, 4, beats each chord step lasts (≥1).
- DEPTH, 8, progression slots (power of 2); AW = log2(DEPTH).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_en  in  1  progression write strobe.
- wr_addr  in  AW  slot to write.
- wr_chord  in  4  chord code to store (0 = rest, 1..7 chord types).
- prog_len  in  AW+1  progression length in slots.
- key_in  in  4  key, 0..11 (C..B).
- loop_en  in  1  wrap to slot 0 at end instead of stopping.
- start  in  1  begin playback (pulse).
- stop  in  1  abort playback (pulse).
- notes_for_chord  in  16  decoded notes, note1 in [15:12] … note4 in [3:0].
- chord_out  out  4  chord code to decoder.
- key_out  out  4  key to decoder.
- playing  out  1  high in PLAY.
- step_idx  out  AW  current slot.
- beat  out  1  one-cycle pulse on last tick of each beat.
- chord_change  out  1  one-cycle pulse when chord_out loads a new step.
- done  out  1  one-cycle pulse at natural end (loop_en=0).
- arp_note  out  4  arpeggiated note.
- arp_valid  out  1  arp_note valid.

Behaviour:
- Reset: all outputs 0 and state IDLE. Progression memory is not cleared.
- States are IDLE and PLAY.
- Writes: wr_en is accepted only in IDLE (mem[wr_addr] <= wr_chord). It is ignored in PLAY.
- Effective length: L = min(prog_len, DEPTH).
- IDLE→PLAY on start when L≠0 and stop=0. In the next cycle:
  - step_idx=0, chord_out=mem[0], key_out=key_in, chord_change=1, playing=1.
  - Tick and beat counters cleared.
- start with L=0 is ignored.
- key_in values 12–15 latch as 0.
- key_out is re-latched at every chord_change only; mid-step key changes take effect at the next step.
- Tick counter 0..TICK_DIV-1. beat pulses when tick=TICK_DIV-1; the beat counter then increments modulo BEATS_PER_CHORD.
- Step end (beat with beat count = BEATS_PER_CHORD-1):
  - step_idx<L-1: advance; chord_change next cycle.
  - step_idx=L-1, loop_en=1: wrap to 0; chord_change.
  - step_idx=L-1, loop_en=0: →IDLE with done=1. chord_out, key_out and playing go to 0 in that same cycle.
- stop in PLAY: →IDLE next cycle, outputs cleared, no done. stop beats start when both are asserted.
- start while in PLAY is ignored.
- rest (code 0) steps still occupy their full duration.
- Latency: chord_out is valid one cycle after start/step end. The decoder is combinational, so notes_for_chord is valid in the same cycle as chord_out.

Optional Feature:
- Macro: CHORD_SEQ_ARPEGGIO_EN.
- Defined:
  - Each beat is split into 4 sub-beats of TICK_DIV/4 ticks.
  - arp_note = note1, note2, note3, note4 of the current notes_for_chord in sub-beats 0..3.
  - arp_valid=1 while playing and chord_out≠0.
  - Registered, 1 cycle behind the tick count.
- Not defined: arp_note=0, arp_valid=0, notes_for_chord unused.

Decomposition:
- Shared package chord_pkg:
  - Note constants C..B (0..11).
  - Chord codes: REST=0, MAJ7=1 … DIM7=7.
  - Note-slot bit offsets for the 16-bit notes word.
- Sub-module seq_timebase: tick/beat/sub-beat counters with beat and step_end strobes. The FSM and memory live in the top.

Test Plan:
- TICK_DIV=8, BEATS_PER_CHORD=2. Write [1,4,5,1], prog_len=4, key_in=2, loop_en=0, start → chord_out 1,4,5,1 for 16 cycles each, key_out=2, chord_change ×4, done 64 cycles after start, then chord_out=0, playing=0.
- Same program, loop_en=1 → after slot 3, step_idx=0, chord_out=1, no done; stop → playing=0 next cycle, no done.
- prog_len=0 then start → stays IDLE, all outputs 0. wr_en during PLAY → memory unchanged, verified after stop.
- start and stop in same cycle → stays IDLE. key_in 5→7 mid-step → key_out=7 only at next chord_change. key_in=13 → key_out=0.
- rst_n low mid-step 2 → all outputs 0 immediately (async). After release, start plays from slot 0 with memory intact.
- With CHORD_SEQ_ARPEGGIO_EN, notes_for_chord=16'h047B → arp_note 0,4,7,11 every 2 cycles per beat. On a rest step, arp_valid=0.
